// File: rtl/pmod_i2c_arbiter_if.sv
// Requester and engine bus of the pmod I2C arbiter.
interface pmod_i2c_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [7*N_REQ-1:0] req_dev;
    logic [8*N_REQ-1:0] req_reg;
    logic [8*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]   req_rnw;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   done;
    logic [7:0]         rsp_rdata;
    logic               rsp_err;
    logic               eng_start;
    logic [6:0]         eng_dev;
    logic [7:0]         eng_reg;
    logic [7:0]         eng_wdata;
    logic               eng_rnw;
    logic               eng_done;
    logic               eng_nack;
    logic [7:0]         eng_rdata;

    // Requesters plus engine: the environment around the arbiter
    modport master (
        output req, req_dev, req_reg, req_wdata, req_rnw,
        output eng_done, eng_nack, eng_rdata,
        input  grant, done, rsp_rdata, rsp_err,
        input  eng_start, eng_dev, eng_reg, eng_wdata, eng_rnw
    );

    // The arbiter itself
    modport slave (
        input  req, req_dev, req_reg, req_wdata, req_rnw,
        input  eng_done, eng_nack, eng_rdata,
        output grant, done, rsp_rdata, rsp_err,
        output eng_start, eng_dev, eng_reg, eng_wdata, eng_rnw
    );
endinterface

// File: rtl/pmod_i2c_arbiter.sv
// Round-robin sharing of one I2C transaction engine, with per-transaction timeout.
module pmod_i2c_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk_256fs,
    input  logic              rst_n,
    pmod_i2c_arbiter_if.slave bus
);
    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT     = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [PW-1:0]      r_rr_ptr;
    logic [CW-1:0]      r_cnt;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_done;
    logic [7:0]         r_rdata;
    logic               r_err;
    logic               r_start;
    logic [6:0]         r_dev;
    logic [7:0]         r_reg;
    logic [7:0]         r_wdata;
    logic               r_rnw;

    logic [PW-1:0]      w_rr_ptr_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [N_REQ-1:0]   w_grant_nxt;
    logic [N_REQ-1:0]   w_done_nxt;
    logic [7:0]         w_rdata_nxt;
    logic               w_err_nxt;
    logic               w_start_nxt;
    logic [6:0]         w_dev_nxt;
    logic [7:0]         w_reg_nxt;
    logic [7:0]         w_wdata_nxt;
    logic               w_rnw_nxt;

    logic               w_found;
    logic [PW-1:0]      w_win;
    logic [N_REQ-1:0]   w_win_oh;
    logic [6:0]         w_sel_dev;
    logic [7:0]         w_sel_reg;
    logic [7:0]         w_sel_wdata;
    logic               w_sel_rnw;

    // First pending requester after the last winner, wrapping modulo N_REQ
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr_ptr;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            if (!w_found && bus.req[PW'((32'(r_rr_ptr) + 32'(i)) % N_REQ)]) begin
                w_found = 1'b1;
                w_win   = PW'((32'(r_rr_ptr) + 32'(i)) % N_REQ);
            end
        end
    end

    assign w_win_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;

    // Winner's transaction fields
    always_comb begin
        w_sel_dev   = '0;
        w_sel_reg   = '0;
        w_sel_wdata = '0;
        w_sel_rnw   = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (w_win == PW'(k)) begin
                w_sel_dev   = bus.req_dev[7*k +: 7];
                w_sel_reg   = bus.req_reg[8*k +: 8];
                w_sel_wdata = bus.req_wdata[8*k +: 8];
                w_sel_rnw   = bus.req_rnw[k];
            end
        end
    end

    // State register
    always_ff @(posedge clk_256fs) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_found) w_state_nxt = S_ISSUE;
            S_ISSUE:    w_state_nxt = S_WAIT;
            S_WAIT:     if (bus.eng_done || (r_cnt == '0)) w_state_nxt = S_COMPLETE;
            S_COMPLETE: w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath; eng_done wins over expiry
    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        w_cnt_nxt    = r_cnt;
        w_grant_nxt  = r_grant;
        w_done_nxt   = '0;
        w_rdata_nxt  = r_rdata;
        w_err_nxt    = r_err;
        w_start_nxt  = 1'b0;
        w_dev_nxt    = r_dev;
        w_reg_nxt    = r_reg;
        w_wdata_nxt  = r_wdata;
        w_rnw_nxt    = r_rnw;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt  = w_win_oh;
                    w_rr_ptr_nxt = w_win;
                    w_dev_nxt    = w_sel_dev;
                    w_reg_nxt    = w_sel_reg;
                    w_wdata_nxt  = w_sel_wdata;
                    w_rnw_nxt    = w_sel_rnw;
                end
            end
            S_ISSUE: begin
                w_start_nxt = 1'b1;
                w_cnt_nxt   = CW'(TIMEOUT_CYCLES);
            end
            S_WAIT: begin
                if (bus.eng_done) begin
                    w_rdata_nxt = bus.eng_rdata;
                    w_err_nxt   = bus.eng_nack;
                    w_done_nxt  = r_grant;
                end else if (r_cnt == '0) begin
                    w_rdata_nxt = 8'h00;
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = r_grant;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_COMPLETE: begin
                w_grant_nxt = '0;
            end
            default: begin
                w_grant_nxt = '0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk_256fs) begin
        if (!rst_n) begin
            r_rr_ptr <= PW'(N_REQ - 1);
            r_cnt    <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_start  <= 1'b0;
            r_dev    <= '0;
            r_reg    <= '0;
            r_wdata  <= '0;
            r_rnw    <= 1'b0;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_grant  <= w_grant_nxt;
            r_done   <= w_done_nxt;
            r_rdata  <= w_rdata_nxt;
            r_err    <= w_err_nxt;
            r_start  <= w_start_nxt;
            r_dev    <= w_dev_nxt;
            r_reg    <= w_reg_nxt;
            r_wdata  <= w_wdata_nxt;
            r_rnw    <= w_rnw_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.done      = r_done;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.eng_start = r_start;
    assign bus.eng_dev   = r_dev;
    assign bus.eng_reg   = r_reg;
    assign bus.eng_wdata = r_wdata;
    assign bus.eng_rnw   = r_rnw;
endmodule

// File: tb/tb_pmod_i2c_arbiter.sv
// Directed scoreboard bench for pmod_i2c_arbiter.
module tb_pmod_i2c_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned TO = 16;

    logic clk_256fs = 1'b0;
    logic rst_n;

    pmod_i2c_arbiter_if #(.N_REQ(N)) bus ();

    pmod_i2c_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_256fs (clk_256fs),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 clk_256fs = ~clk_256fs;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         idx;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic       rnw;
        int         delay;
        logic       nack;
        logic [7:0] rdata;
        bit         timeout;
        bit         drop;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] outs();
        return {bus.grant, bus.done, bus.rsp_rdata, bus.rsp_err, bus.eng_start,
                bus.eng_dev, bus.eng_reg, bus.eng_wdata, bus.eng_rnw};
    endfunction

    task automatic set_req(input int i, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input logic rnw);
        bus.req_dev[7*i +: 7]   = dev;
        bus.req_reg[8*i +: 8]   = rg;
        bus.req_wdata[8*i +: 8] = wd;
        bus.req_rnw[i]          = rnw;
    endtask

    task automatic push(input int i, input int delay, input logic nack, input logic [7:0] rdata,
                        input bit timeout, input bit drop);
        exp_t e;
        e.idx     = i;
        e.dev     = bus.req_dev[7*i +: 7];
        e.rg      = bus.req_reg[8*i +: 8];
        e.wd      = bus.req_wdata[8*i +: 8];
        e.rnw     = bus.req_rnw[i];
        e.delay   = delay;
        e.nack    = nack;
        e.rdata   = rdata;
        e.timeout = timeout;
        e.drop    = drop;
        sb.push_back(e);
    endtask

    task automatic reset_dut(input bit check);
        @(negedge clk_256fs);
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.eng_done  = 1'b0;
        bus.eng_nack  = 1'b0;
        bus.eng_rdata = 8'h00;
        repeat (2) @(negedge clk_256fs);
        if (check) chk("reset_outputs", 64'(outs()), 64'(0));
        rst_n = 1'b1;
        @(negedge clk_256fs);
    endtask

    // Serves the oldest scoreboard entry: waits for its launch, answers as the engine, checks the result
    task automatic run_txn();
        exp_t       e;
        int         n;
        bit         seen;
        logic [N-1:0] oh;
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 64'(0), 64'(1));
            return;
        end
        e = sb.pop_front();
        oh = '0;
        oh[e.idx] = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            n++;
            @(negedge clk_256fs);
            if (bus.eng_start) seen = 1'b1;
        end
        chk("start_seen", 64'(seen), 64'(1));
        if (!seen) return;
        chk("req_to_start", 64'(n), 64'(2));
        chk("grant", 64'(bus.grant), 64'(oh));
        chk("eng_fields", 64'({bus.eng_dev, bus.eng_reg, bus.eng_wdata, bus.eng_rnw}),
            64'({e.dev, e.rg, e.wd, e.rnw}));
        bus.req_wdata[8*e.idx +: 8] = ~e.wd;
        if (!e.timeout) begin
            for (int k = 0; k < e.delay; k++) begin
                @(negedge clk_256fs);
                if (k == 0) chk("start_one_cycle", 64'(bus.eng_start), 64'(0));
            end
            bus.eng_done  = 1'b1;
            bus.eng_nack  = e.nack;
            bus.eng_rdata = e.rdata;
            @(negedge clk_256fs);
            bus.eng_done = 1'b0;
            chk("done", 64'(bus.done), 64'(oh));
            chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
            chk("rsp_err", 64'(bus.rsp_err), 64'(e.nack));
        end else begin
            n = 0;
            seen = 1'b0;
            while (!seen && n < 40) begin
                n++;
                @(negedge clk_256fs);
                if (n == 1) chk("start_one_cycle", 64'(bus.eng_start), 64'(0));
                if (bus.done != '0) seen = 1'b1;
            end
            chk("timeout_seen", 64'(seen), 64'(1));
            chk("timeout_latency", 64'(n), 64'(TO + 1));
            chk("timeout_done", 64'(bus.done), 64'(oh));
            chk("timeout_rdata", 64'(bus.rsp_rdata), 64'(0));
            chk("timeout_err", 64'(bus.rsp_err), 64'(1));
            bus.eng_done  = 1'b1;
            bus.eng_nack  = 1'b0;
            bus.eng_rdata = 8'hFF;
        end
        chk("fields_stable", 64'({bus.eng_dev, bus.eng_reg, bus.eng_wdata, bus.eng_rnw}),
            64'({e.dev, e.rg, e.wd, e.rnw}));
        bus.req_wdata[8*e.idx +: 8] = e.wd;
        if (e.drop) bus.req[e.idx] = 1'b0;
        @(negedge clk_256fs);
        bus.eng_done = 1'b0;
        chk("grant_release", 64'(bus.grant), 64'(0));
        chk("done_one_cycle", 64'(bus.done), 64'(0));
        if (e.timeout) chk("late_eng_done_ignored", 64'({bus.rsp_err, bus.rsp_rdata}), 64'({1'b1, 8'h00}));
    endtask

    initial begin
        int  n;
        bit  seen;
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.req_dev   = '0;
        bus.req_reg   = '0;
        bus.req_wdata = '0;
        bus.req_rnw   = '0;
        bus.eng_done  = 1'b0;
        bus.eng_nack  = 1'b0;
        bus.eng_rdata = 8'h00;
        reset_dut(1'b1);

        // eng_done while idle must not produce anything
        bus.eng_done  = 1'b1;
        bus.eng_nack  = 1'b1;
        bus.eng_rdata = 8'h99;
        @(negedge clk_256fs);
        bus.eng_done = 1'b0;
        chk("idle_eng_done_ignored", 64'(outs()), 64'(0));

        // T1: single write, ACK 10 cycles after start
        set_req(0, 7'h10, 8'h05, 8'hA5, 1'b0);
        push(0, 10, 1'b0, 8'h77, 1'b0, 1'b1);
        bus.req[0] = 1'b1;
        run_txn();

        // T2: two simultaneous requests
        reset_dut(1'b0);
        set_req(0, 7'h11, 8'h01, 8'h11, 1'b0);
        set_req(2, 7'h22, 8'h02, 8'h22, 1'b1);
        push(0, 3, 1'b0, 8'h01, 1'b0, 1'b1);
        push(2, 4, 1'b0, 8'h02, 1'b0, 1'b1);
        bus.req = 4'b0101;
        run_txn();
        run_txn();

        // T3: all four held high, rotation 0,1,2,3,0,1
        reset_dut(1'b0);
        for (int i = 0; i < 4; i++) set_req(i, 7'(7'h30 + i), 8'(8'h40 + i), 8'(8'hB0 + i), 1'(i % 2));
        push(0, 1, 1'b0, 8'hE0, 1'b0, 1'b0);
        push(1, 2, 1'b0, 8'hE1, 1'b0, 1'b0);
        push(2, 3, 1'b0, 8'hE2, 1'b0, 1'b0);
        push(3, 4, 1'b0, 8'hE3, 1'b0, 1'b0);
        push(0, 5, 1'b0, 8'hE4, 1'b0, 1'b0);
        push(1, 6, 1'b0, 8'hE5, 1'b0, 1'b0);
        bus.req = 4'b1111;
        repeat (6) run_txn();
        bus.req = '0;

        // T4: timeout, last winner was 1 so requester 2 is next in line
        set_req(2, 7'h50, 8'h0A, 8'h5A, 1'b0);
        push(2, 0, 1'b0, 8'h00, 1'b1, 1'b1);
        bus.req[2] = 1'b1;
        run_txn();

        // T5: read with NACK, then eng_done exactly at expiry with ACK and with NACK
        set_req(1, 7'h51, 8'h0B, 8'h00, 1'b1);
        push(1, 5, 1'b1, 8'h3C, 1'b0, 1'b1);
        bus.req[1] = 1'b1;
        run_txn();
        set_req(3, 7'h53, 8'h0C, 8'h00, 1'b1);
        push(3, TO, 1'b0, 8'h5A, 1'b0, 1'b1);
        bus.req[3] = 1'b1;
        run_txn();
        set_req(0, 7'h54, 8'h0D, 8'h00, 1'b1);
        push(0, TO, 1'b1, 8'hC3, 1'b0, 1'b1);
        bus.req[0] = 1'b1;
        run_txn();

        // T6: reset during WAIT aborts silently, then requester 0 wins over 3
        reset_dut(1'b0);
        set_req(0, 7'h60, 8'h10, 8'h61, 1'b0);
        bus.req = 4'b0001;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            n++;
            @(negedge clk_256fs);
            if (bus.eng_start) seen = 1'b1;
        end
        chk("t6_start_seen", 64'(seen), 64'(1));
        repeat (3) @(negedge clk_256fs);
        rst_n = 1'b0;
        @(negedge clk_256fs);
        chk("reset_in_wait", 64'(outs()), 64'(0));
        repeat (3) begin
            @(negedge clk_256fs);
            chk("no_done_in_reset", 64'(bus.done), 64'(0));
        end
        set_req(0, 7'h62, 8'h12, 8'h63, 1'b1);
        set_req(3, 7'h6F, 8'h1F, 8'h6E, 1'b0);
        push(0, 2, 1'b0, 8'h81, 1'b0, 1'b1);
        push(3, 2, 1'b1, 8'h82, 1'b0, 1'b1);
        bus.req = 4'b1001;
        rst_n = 1'b1;
        run_txn();
        run_txn();
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
